ifu_prefetch: RTL

Parametrised instruction fetch unit with an in-order prefetch queue, replacing the single-request fetch FSM between the AXI instruction SRAM and the IDU. It keeps up to FIFO_DEPTH read requests in flight or buffered, so that one instruction per cycle can be delivered once the pipeline is primed. On Jump_flag it flushes the queue and discards in-flight responses. Read errors are forwarded to the IDU as tagged entries rather than being retried.

---
 rtl/ifu_prefetch_if.sv | 30 +++
 rtl/ifu_prefetch.sv | 139 +++++++++++++
 2 files changed

// File: rtl/ifu_prefetch_if.sv
// Instruction-fetch bundle: AXI read address/data channels plus the IDU handshake.
// The master side is the IFU; the slave side is the SRAM/IDU environment.
interface ifu_prefetch_if #(
    parameter int unsigned DATA_LEN = 32
);
    logic                arvalid;
    logic                arready;
    logic [DATA_LEN-1:0] araddr;
    logic                rvalid;
    logic [DATA_LEN-1:0] rdata;
    logic [1:0]          rresp;
    logic                rready;
    logic                inst_valid;
    logic                inst_ready;
    logic [DATA_LEN-1:0] inst_fetch;
    logic [DATA_LEN-1:0] PC_now;
    logic                inst_err;

    modport master (
        output arvalid, araddr, rready,
        output inst_valid, inst_fetch, PC_now, inst_err,
        input  arready, rvalid, rdata, rresp, inst_ready
    );

    modport slave (
        input  arvalid, araddr, rready,
        input  inst_valid, inst_fetch, PC_now, inst_err,
        output arready, rvalid, rdata, rresp, inst_ready
    );
endinterface

// File: rtl/ifu_prefetch.sv
// Prefetching instruction fetch unit: keeps up to FIFO_DEPTH reads in flight or
// buffered, delivers in order to the IDU and drops stale responses on redirect.
module ifu_prefetch #(
    parameter int unsigned          DATA_LEN   = 32,
    parameter int unsigned          FIFO_DEPTH = 4,
    parameter logic [DATA_LEN-1:0] RST_PC     = 32'h8000_0000,
    parameter logic [DATA_LEN-1:0] NOP_INST   = 32'h0000_0013
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                Jump_flag,
    input  logic [DATA_LEN-1:0] Jump_PC,
    ifu_prefetch_if.master      bus
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [0:0] AR_IDLE = 1'b0;
    localparam logic [0:0] AR_WAIT = 1'b1;

    typedef logic [CW-1:0] cnt_t;
    typedef logic [CW:0]   sum_t;
    typedef logic [PW-1:0] idx_t;

    logic [0:0]          state_q, state_d;
    logic [DATA_LEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [DATA_LEN-1:0] araddr_q, araddr_d;
    cnt_t                out_cnt_q, out_cnt_d;
    cnt_t                drop_cnt_q, drop_cnt_d;
    cnt_t                rd_q, rd_d, wr_q, wr_d;
    logic                stale_q, stale_d;
    idx_t                pq_rd_q, pq_wr_q;

    logic [DATA_LEN-1:0] pq_mem_q [FIFO_DEPTH];
    logic [DATA_LEN-1:0] pc_mem_q [FIFO_DEPTH];
    logic [DATA_LEN-1:0] in_mem_q [FIFO_DEPTH];
    logic                er_mem_q [FIFO_DEPTH];

    logic ar_acc, r_drop, f_push, f_pop, f_empty, issue_ok;
    idx_t head;
    cnt_t cnt_d;
    sum_t credit_d;

    assign ar_acc  = (state_q == AR_WAIT) && bus.arready;
    assign r_drop  = bus.rvalid && (drop_cnt_q != '0);
    assign f_push  = bus.rvalid && !r_drop && !Jump_flag;
    assign f_empty = (rd_q == wr_q);
    assign f_pop   = !f_empty && bus.inst_ready && !Jump_flag;
    assign head    = rd_q[PW-1:0];

    always_comb begin
        out_cnt_d  = out_cnt_q + cnt_t'(ar_acc) - cnt_t'(bus.rvalid);
        drop_cnt_d = drop_cnt_q - cnt_t'(r_drop)
                   + cnt_t'(ar_acc && stale_q);
        fetch_pc_d = fetch_pc_q;
        stale_d    = stale_q && !ar_acc;
        rd_d       = rd_q + cnt_t'(f_pop);
        wr_d       = wr_q + cnt_t'(f_push);
        // A stale held address was never taken from fetch_pc.
        if (ar_acc && !stale_q) begin
            fetch_pc_d = fetch_pc_q + DATA_LEN'(4);
        end
        if (Jump_flag) begin
            fetch_pc_d = Jump_PC;
            drop_cnt_d = out_cnt_d;
            stale_d    = (state_q == AR_WAIT) && !bus.arready;
            rd_d       = '0;
            wr_d       = '0;
        end
    end

    // Issue decision uses next-cycle occupancy, so a redirect launches at once.
    always_comb begin
        cnt_d    = wr_d - rd_d;
        credit_d = sum_t'(out_cnt_d) + sum_t'(cnt_d);
        issue_ok = credit_d < sum_t'(FIFO_DEPTH);
        state_d  = state_q;
        araddr_d = araddr_q;
        if ((state_q == AR_IDLE) || ar_acc) begin
            state_d  = issue_ok ? AR_WAIT : AR_IDLE;
            araddr_d = issue_ok ? fetch_pc_d : araddr_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= AR_IDLE;
            fetch_pc_q <= RST_PC;
            araddr_q   <= RST_PC;
            out_cnt_q  <= '0;
            drop_cnt_q <= '0;
            rd_q       <= '0;
            wr_q       <= '0;
            stale_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            araddr_q   <= araddr_d;
            out_cnt_q  <= out_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            stale_q    <= stale_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                pq_mem_q[i] <= '0;
                pc_mem_q[i] <= '0;
                in_mem_q[i] <= '0;
                er_mem_q[i] <= 1'b0;
            end
            pq_rd_q <= '0;
            pq_wr_q <= '0;
        end else begin
            if (ar_acc) begin
                pq_mem_q[pq_wr_q] <= araddr_q;
                pq_wr_q           <= pq_wr_q + idx_t'(1);
            end
            if (bus.rvalid) begin
                pq_rd_q <= pq_rd_q + idx_t'(1);
            end
            if (f_push) begin
                pc_mem_q[wr_q[PW-1:0]] <= pq_mem_q[pq_rd_q];
                in_mem_q[wr_q[PW-1:0]] <= bus.rdata;
                er_mem_q[wr_q[PW-1:0]] <= (bus.rresp != 2'b00);
            end
        end
    end

    assign bus.arvalid    = (state_q == AR_WAIT);
    assign bus.araddr     = araddr_q;
    assign bus.rready     = 1'b1;
    assign bus.inst_valid = !f_empty;
    assign bus.inst_fetch = f_empty ? NOP_INST : in_mem_q[head];
    assign bus.PC_now     = f_empty ? fetch_pc_q : pc_mem_q[head];
    assign bus.inst_err   = !f_empty && er_mem_q[head];
endmodule
